// File: rtl/adc_cfg_pkg.sv
`default_nettype none
// ============================================================================
// adc_cfg_pkg : FSM states and cfg register map for the ADC cfg initiator
// Rev 1.0
// ============================================================================
package adc_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } cfg_init_state_e;

  localparam logic [10:0] CFG_ADDR_FLAGS_EN   = 11'h0FC;
  localparam logic [10:0] CFG_ADDR_FLAGS_DATA = 11'h0FD;

  // Reads drive zero on the data lines so the responder never sees stale write data.
  function automatic logic [31:0] cfg_beat_data(input logic rwn, input logic [31:0] wdata);
    return rwn ? 32'd0 : wdata;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_cfg_poll_timer.sv
`default_nettype none
// ============================================================================
// adc_cfg_poll_timer : period counter with a one-deep poll-pending flag
// Rev 1.0
// ============================================================================
module adc_cfg_poll_timer #(
  parameter int POLL_PERIOD_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic [POLL_PERIOD_W-1:0] i_period,
  input  logic                     i_clr,
  output logic                     o_pending
);

  logic [POLL_PERIOD_W-1:0] r_cnt;
  logic                     r_pending;
  logic                     w_expire;

  assign w_expire  = (r_cnt == i_period);
  assign o_pending = r_pending;

  // A fresh expiry outranks the consume strobe so no period is ever lost.
  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_cnt <= w_expire ? '0 : r_cnt + 1'b1;
      if (w_expire) begin
        r_pending <= 1'b1;
      end else if (i_clr) begin
        r_pending <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_cfg_initiator.sv
`default_nettype none
// ============================================================================
// adc_cfg_initiator : host/poll requests to single-beat cfg bus transactions
// Rev 1.0
// ============================================================================
module adc_cfg_initiator
  import adc_cfg_pkg::*;
#(
  parameter int CFG_AWIDTH     = 11,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int POLL_PERIOD_W  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [CFG_AWIDTH-1:0]    req_addr_i,
  input  logic [31:0]              req_wdata_i,
  input  logic                     req_rwn_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_rdata_o,
  output logic                     rsp_err_o,
  input  logic                     poll_en_i,
  input  logic [CFG_AWIDTH-1:0]    poll_addr_i,
  input  logic [POLL_PERIOD_W-1:0] poll_period_i,
  output logic                     poll_evt_o,
  output logic [31:0]              poll_data_o,
  output logic                     cfg_valid_o,
  output logic                     cfg_rwn_o,
  output logic [CFG_AWIDTH-1:0]    cfg_addr_o,
  output logic [31:0]              cfg_data_o,
  input  logic [31:0]              cfg_data_i,
  input  logic                     cfg_ready_i
);

  localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCNT_W-1:0] c_TMAX = TCNT_W'(TIMEOUT_CYCLES - 1);

  cfg_init_state_e         r_state;
  logic                    r_src_poll;
  logic [CFG_AWIDTH-1:0]   r_addr;
  logic                    r_rwn;
  logic [31:0]             r_cfg_wdata;
  logic [TCNT_W-1:0]       r_tcnt;
  logic [31:0]             r_rdata;
  logic                    r_err;
  logic                    r_poll_evt;
  logic [31:0]             r_poll_data;
  logic                    w_poll_pending;
  logic                    w_poll_take;

  assign w_poll_take = (r_state == ST_IDLE) && !req_valid_i && w_poll_pending;

  adc_cfg_poll_timer #(
    .POLL_PERIOD_W (POLL_PERIOD_W)
  ) u_poll_timer (
    .clk       (clk_i),
    .rst       (rst_i),
    .i_en      (poll_en_i),
    .i_period  (poll_period_i),
    .i_clr     (w_poll_take),
    .o_pending (w_poll_pending)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_src_poll  <= 1'b0;
      r_addr      <= '0;
      r_rwn       <= 1'b0;
      r_cfg_wdata <= '0;
      r_tcnt      <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_poll_evt  <= 1'b0;
      r_poll_data <= '0;
    end else begin
      r_poll_evt <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tcnt <= '0;
          if (req_valid_i) begin
            r_addr      <= req_addr_i;
            r_rwn       <= req_rwn_i;
            r_cfg_wdata <= cfg_beat_data(req_rwn_i, req_wdata_i);
            r_src_poll  <= 1'b0;
            r_state     <= ST_ISSUE;
          end else if (w_poll_pending) begin
            r_addr      <= poll_addr_i;
            r_rwn       <= 1'b1;
            r_cfg_wdata <= '0;
            r_src_poll  <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cfg_ready_i) begin
            if (r_src_poll) begin
              if (cfg_data_i != 32'd0) begin
                r_poll_data <= cfg_data_i;
                r_poll_evt  <= 1'b1;
              end
              r_state <= ST_IDLE;
            end else begin
              r_rdata <= r_rwn ? cfg_data_i : 32'd0;
              r_err   <= 1'b0;
              r_state <= ST_RESP;
            end
          end else if (r_tcnt == c_TMAX) begin
            // A timed-out poll is dropped silently; only host requests report errors.
            if (r_src_poll) begin
              r_state <= ST_IDLE;
            end else begin
              r_rdata <= 32'd0;
              r_err   <= 1'b1;
              r_state <= ST_RESP;
            end
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = (r_state == ST_IDLE);
  assign cfg_valid_o = (r_state == ST_ISSUE);
  assign rsp_valid_o = (r_state == ST_RESP);
  assign cfg_rwn_o   = r_rwn;
  assign cfg_addr_o  = r_addr;
  assign cfg_data_o  = r_cfg_wdata;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
  assign poll_evt_o  = r_poll_evt;
  assign poll_data_o = r_poll_data;

endmodule
`default_nettype wire

// File: tb/tb_adc_cfg_initiator.sv
`default_nettype none
// ============================================================================
// tb_adc_cfg_initiator : directed + randomized checks against a transaction model
// Rev 1.0
// ============================================================================
module tb_adc_cfg_initiator;
  import adc_cfg_pkg::*;

  localparam int AW = 11;
  localparam int TO = 16;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i = '0;
  logic [31:0]   req_wdata_i = '0;
  logic          req_rwn_i = 1'b0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic          poll_en_i = 1'b0;
  logic [AW-1:0] poll_addr_i = '0;
  logic [PW-1:0] poll_period_i = '0;
  logic          poll_evt_o;
  logic [31:0]   poll_data_o;
  logic          cfg_valid_o;
  logic          cfg_rwn_o;
  logic [AW-1:0] cfg_addr_o;
  logic [31:0]   cfg_data_o;
  logic [31:0]   cfg_data_i = '0;
  logic          cfg_ready_i = 1'b0;

  always #5 clk = ~clk;

  adc_cfg_initiator #(
    .CFG_AWIDTH     (AW),
    .TIMEOUT_CYCLES (TO),
    .POLL_PERIOD_W  (PW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .req_rwn_i     (req_rwn_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o),
    .poll_en_i     (poll_en_i),
    .poll_addr_i   (poll_addr_i),
    .poll_period_i (poll_period_i),
    .poll_evt_o    (poll_evt_o),
    .poll_data_o   (poll_data_o),
    .cfg_valid_o   (cfg_valid_o),
    .cfg_rwn_o     (cfg_rwn_o),
    .cfg_addr_o    (cfg_addr_o),
    .cfg_data_o    (cfg_data_o),
    .cfg_data_i    (cfg_data_i),
    .cfg_ready_i   (cfg_ready_i)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [31:0] pq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One host transaction; responder asserts ready after ready_delay cycles of cfg_valid.
  task automatic host_txn(input logic rwn, input logic [AW-1:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ready_delay, input int rsp_delay);
    int   n;
    int   w;
    int   exp_vcyc;
    logic exp_err;
    logic [31:0] exp_rdata;
    exp_err   = (ready_delay >= TO);
    exp_vcyc  = exp_err ? TO : ready_delay + 1;
    exp_rdata = (rwn && !exp_err) ? rdata : 32'd0;
    w = 0;
    while (!req_ready_o && w < 40) begin
      step();
      w++;
    end
    chk("host_idle_ready", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_rwn_i   = rwn;
    cfg_ready_i = 1'b0;
    step();
    req_valid_i = 1'b0;
    req_addr_i  = AW'($urandom);
    req_wdata_i = $urandom;
    req_rwn_i   = 1'($urandom);
    chk("host_cfg_valid", cfg_valid_o, 1);
    chk("host_cfg_addr", cfg_addr_o, addr);
    chk("host_cfg_rwn", cfg_rwn_o, rwn);
    chk("host_cfg_data", cfg_data_o, rwn ? 32'd0 : wdata);
    chk("host_busy_ready", req_ready_o, 0);
    n = 0;
    while (cfg_valid_o && n < 40) begin
      if (n == ready_delay) begin
        cfg_ready_i = 1'b1;
        cfg_data_i  = rdata;
      end else begin
        cfg_ready_i = 1'b0;
        cfg_data_i  = $urandom;
      end
      step();
      n++;
    end
    cfg_ready_i = 1'b0;
    cfg_data_i  = $urandom;
    chk("host_valid_cycles", n, exp_vcyc);
    chk("host_rsp_valid", rsp_valid_o, 1);
    chk("host_rsp_rdata", rsp_rdata_o, exp_rdata);
    chk("host_rsp_err", rsp_err_o, exp_err);
    for (int i = 0; i < rsp_delay; i++) begin
      step();
      chk("host_rsp_hold_valid", rsp_valid_o, 1);
      chk("host_rsp_hold_rdata", rsp_rdata_o, exp_rdata);
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk("host_rsp_done", rsp_valid_o, 0);
    chk("host_back_idle", req_ready_o, 1);
  endtask

  // Poll run: responder always ready, returns pq entries then zeros.
  task automatic poll_run(input int p, input logic [AW-1:0] a, input int nb,
                          input int exp_evts, input logic [31:0] exp_pdata);
    int   bc[$];
    int   evts;
    int   exp_gap;
    logic beat;
    evts    = 0;
    exp_gap = (p + 1 < 2) ? 2 : p + 1;
    poll_period_i = PW'(p);
    poll_addr_i   = a;
    cfg_ready_i   = 1'b1;
    cfg_data_i    = (pq.size() > 0) ? pq[0] : 32'd0;
    poll_en_i     = 1'b1;
    for (int k = 0; k < 300; k++) begin
      beat = cfg_valid_o;
      if (beat) begin
        bc.push_back(cyc);
        chk("poll_addr", cfg_addr_o, a);
        chk("poll_rwn", cfg_rwn_o, 1);
      end
      step();
      if (beat) begin
        if (pq.size() > 0) void'(pq.pop_front());
        cfg_data_i = (pq.size() > 0) ? pq[0] : 32'd0;
      end
      if (poll_evt_o) evts++;
      if (rsp_valid_o) chk("poll_no_rsp", rsp_valid_o, 0);
      if (bc.size() == nb) break;
    end
    poll_en_i  = 1'b0;
    cfg_data_i = 32'd0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (poll_evt_o) evts++;
    end
    cfg_ready_i = 1'b0;
    chk("poll_beats", bc.size(), nb);
    for (int i = 1; i < bc.size(); i++) begin
      chk("poll_interval", bc[i] - bc[i-1], exp_gap);
    end
    chk("poll_evt_count", evts, exp_evts);
    chk("poll_data", poll_data_o, exp_pdata);
    chk("poll_idle_after", req_ready_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_i = 1'b1;
    repeat (3) step();
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_cfg_valid", cfg_valid_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_rdata", rsp_rdata_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_poll_evt", poll_evt_o, 0);
    chk("rst_poll_data", poll_data_o, 0);
    rst_i = 1'b0;
    step();

    // Directed host transactions
    host_txn(1'b0, CFG_ADDR_FLAGS_EN, 32'h1, 32'hDEAD_BEEF, 0, 0);
    host_txn(1'b1, CFG_ADDR_FLAGS_DATA, 32'h0, 32'hA5A5_0001, 0, 0);
    host_txn(1'b1, CFG_ADDR_FLAGS_DATA, 32'h0, 32'h1111_2222, 100, 1);
    host_txn(1'b0, 11'h3A1, 32'hCAFE_F00D, 32'h0, 100, 0);

    // Polling: zero, zero, then non-zero
    pq.delete();
    pq.push_back(32'h0);
    pq.push_back(32'h0);
    pq.push_back(32'h8);
    poll_run(4, CFG_ADDR_FLAGS_DATA, 3, 1, 32'h8);

    // Random period, all-zero data: no events, last non-zero result retained
    pq.delete();
    poll_run($urandom_range(0, 6), AW'($urandom), 4, 0, 32'h8);

    // Arbitration: host request and pending poll in the same IDLE cycle
    pq.delete();
    poll_period_i = PW'(3);
    poll_addr_i   = CFG_ADDR_FLAGS_DATA;
    cfg_ready_i   = 1'b1;
    cfg_data_i    = 32'h1234_5678;
    poll_en_i     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (cfg_valid_o) chk("arb_no_early_poll", cfg_valid_o, 0);
    end
    req_valid_i = 1'b1;
    req_addr_i  = 11'h123;
    req_rwn_i   = 1'b1;
    step();
    req_valid_i = 1'b0;
    chk("arb_host_first_valid", cfg_valid_o, 1);
    chk("arb_host_first_addr", cfg_addr_o, 11'h123);
    step();
    cfg_data_i = 32'h0;
    chk("arb_rsp_valid", rsp_valid_o, 1);
    chk("arb_rsp_rdata", rsp_rdata_o, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("arb_hold_rdata", rsp_rdata_o, 32'h1234_5678);
      chk("arb_hold_no_beat", cfg_valid_o, 0);
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk("arb_idle", req_ready_o, 1);
    step();
    chk("arb_poll_valid", cfg_valid_o, 1);
    chk("arb_poll_addr", cfg_addr_o, CFG_ADDR_FLAGS_DATA);
    chk("arb_poll_rwn", cfg_rwn_o, 1);
    poll_en_i = 1'b0;
    repeat (3) step();
    cfg_ready_i = 1'b0;

    // Randomized host transactions
    for (int t = 0; t < 12; t++) begin
      logic        rwn;
      int          dly;
      rwn = 1'($urandom);
      dly = ($urandom_range(0, 4) == 0) ? TO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 4));
      host_txn(rwn, AW'($urandom), $urandom, $urandom, dly, $urandom_range(0, 3));
    end

    // Reset while a beat is outstanding
    req_valid_i = 1'b1;
    req_addr_i  = CFG_ADDR_FLAGS_DATA;
    req_rwn_i   = 1'b1;
    cfg_ready_i = 1'b0;
    step();
    req_valid_i = 1'b0;
    chk("mid_rst_in_issue", cfg_valid_o, 1);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("mid_rst_cfg_valid", cfg_valid_o, 0);
    chk("mid_rst_req_ready", req_ready_o, 1);
    chk("mid_rst_rsp_valid", rsp_valid_o, 0);
    chk("mid_rst_poll_data", poll_data_o, 0);
    repeat (3) begin
      step();
      chk("mid_rst_no_rsp", rsp_valid_o, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
